// File: rtl/sprite_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : sprite_row_fetcher
// Description : Round-robin arbiter that shares one sprite ROM. It bursts one
//               row of addresses per grant and returns tagged pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_row_fetcher #(
    parameter int N_REQ  = 4,
    parameter int SPR_W  = 40,
    parameter int SPR_H  = 38,
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 6,
    parameter int COL_W  = 6,
    parameter int ID_W   = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ROW_W-1:0]   req_row,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     err,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [23:0]              rom_data,
    output logic                     pix_valid,
    output logic [23:0]              pix_data,
    output logic [ID_W-1:0]          pix_id,
    output logic [COL_W-1:0]         pix_col,
    output logic                     pix_last
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(SPR_W - 1);
    localparam logic [ID_W-1:0]  c_RR_INIT  = ID_W'(N_REQ - 1);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [COL_W-1:0]    r_col;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [N_REQ-1:0]    r_grant;
    logic                r_err;

    logic                r_t1_valid;
    logic [ID_W-1:0]     r_t1_id;
    logic [COL_W-1:0]    r_t1_col;
    logic                r_t1_last;

    logic                r_pix_valid;
    logic [23:0]         r_pix_data;
    logic [ID_W-1:0]     r_pix_id;
    logic [COL_W-1:0]    r_pix_col;
    logic                r_pix_last;

    logic                w_found;
    logic [ID_W-1:0]     w_sel;
    logic [ROW_W-1:0]    w_row;
    logic                w_row_ok;
    logic [ADDR_W-1:0]   w_base;
    logic [N_REQ-1:0]    w_onehot;

    // Search starts one past the last winner and wraps modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_found && req[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_sel   = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign w_row    = req_row[w_sel*ROW_W +: ROW_W];
    assign w_row_ok = (int'(w_row) < SPR_H);
    assign w_base   = ADDR_W'(int'(w_row) * SPR_W);
    assign w_onehot = N_REQ'(1) << w_sel;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= c_RR_INIT;
            r_id        <= '0;
            r_col       <= '0;
            r_rom_addr  <= '0;
            r_grant     <= '0;
            r_err       <= 1'b0;
            r_t1_valid  <= 1'b0;
            r_t1_id     <= '0;
            r_t1_col    <= '0;
            r_t1_last   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_id    <= '0;
            r_pix_col   <= '0;
            r_pix_last  <= 1'b0;
        end else begin
            r_grant     <= '0;
            r_err       <= 1'b0;

            r_t1_valid  <= (r_state == BURST);
            r_t1_id     <= r_id;
            r_t1_col    <= r_col;
            r_t1_last   <= (r_state == BURST) && (r_col == c_LAST_COL);

            r_pix_valid <= r_t1_valid;
            r_pix_id    <= r_t1_id;
            r_pix_col   <= r_t1_col;
            r_pix_last  <= r_t1_last;
            r_pix_data  <= rom_data;

            case (r_state)
                IDLE: begin
                    // A grant pulse still in flight blocks arbitration, so
                    // an error grant is never followed by a back-to-back one.
                    if (w_found && (r_grant == '0)) begin
                        r_grant  <= w_onehot;
                        r_rr_ptr <= w_sel;
                        if (w_row_ok) begin
                            r_state    <= BURST;
                            r_id       <= w_sel;
                            r_col      <= '0;
                            r_rom_addr <= w_base;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (r_col == c_LAST_COL) begin
                        r_state <= IDLE;
                    end else begin
                        r_col      <= r_col + COL_W'(1);
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign busy      = (r_state == BURST);
    assign err       = r_err;
    assign rom_addr  = r_rom_addr;
    assign pix_valid = r_pix_valid;
    assign pix_data  = r_pix_data;
    assign pix_id    = r_pix_id;
    assign pix_col   = r_pix_col;
    assign pix_last  = r_pix_last;

endmodule
`default_nettype wire
